// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit lab processor: opcodes, instruction field
// positions, fetch defaults and the fetch buffer entry layout.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
    localparam int unsigned DEFAULT_IM_DEPTH = 1024;

    localparam int unsigned OPC_HI  = 31;
    localparam int unsigned OPC_LO  = 25;
    localparam int unsigned RD_HI   = 24;
    localparam int unsigned RD_LO   = 20;
    localparam int unsigned RS1_HI  = 19;
    localparam int unsigned RS1_LO  = 15;
    localparam int unsigned IMM_HI  = 14;
    localparam int unsigned IMM_LO  = 0;

    typedef enum logic [6:0] {
        OP_NOP = 7'h00,
        OP_ADD = 7'h01,
        OP_SUB = 7'h02,
        OP_AND = 7'h03,
        OP_OR  = 7'h04,
        OP_LD  = 7'h08,
        OP_ST  = 7'h09,
        OP_BZ  = 7'h10,
        OP_BNZ = 7'h11,
        OP_JMP = 7'h12,
        OP_JMR = 7'h13,
        OP_JML = 7'h14
    } opcode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of {pc, ir} entries between fetch and decode.
// Flush has priority over push and pop.
module fetch_buf
    import cpu_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         not_empty,
    output logic [AW:0]  count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // NOTE: storage is left unreset; count decides whether any slot is meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head      = mem[rd_ptr];
    assign not_empty = (count != '0);

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC and halt flag, feeds fetched words into
// fetch_buf and hands them to decode over valid/ready.
module ifetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned IM_DEPTH  = DEFAULT_IM_DEPTH,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    input  logic [31:0] ir_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    output logic [31:0] id_ir_o,
    output logic [31:0] id_pc_o,
    input  logic        id_ready_i,
    output logic        halt_o
);

    localparam int unsigned    CW         = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0]  BUF_FULL   = CW'(BUF_DEPTH);
    localparam logic [31:0]    IM_END     = 32'(IM_DEPTH);
    localparam logic           RESET_HALT = (RESET_PC >= IM_END);

    logic [31:0]   pc;
    logic [31:0]   pc_inc;
    logic          halt;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic          not_empty;
    fetch_entry_t  entry_in;
    fetch_entry_t  head;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        pc_inc      = pc + 32'd1;
        pop         = not_empty & id_ready_i;
        push        = !redirect_i & !halt & ((count < BUF_FULL) | pop);
        entry_in.pc = pc;
        entry_in.ir = ir_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc   <= RESET_PC;
            halt <= RESET_HALT;
        end else if (redirect_i) begin
            pc   <= redirect_pc_i;
            halt <= (redirect_pc_i >= IM_END);
        end else if (push) begin
            pc   <= pc_inc;
            halt <= (pc_inc == IM_END);
        end
    end

    // The redirect doubles as the flush, so a same-cycle pop still consumes the head.
    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_i),
        .din       (entry_in),
        .head      (head),
        .not_empty (not_empty),
        .count     (count)
    );

    assign pc_o       = pc;
    assign halt_o     = halt;
    assign id_valid_o = not_empty;
    assign id_ir_o    = not_empty ? head.ir : '0;
    assign id_pc_o    = not_empty ? head.pc : '0;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: stimulus queues expected decode handshakes,
// per-instance monitors pop and compare on every valid & ready.
module tb_ifetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    logic clk;

    logic        rst_n_a, redir_a, ready_a, valid_a, halt_a;
    logic [31:0] redir_pc_a, pc_a, ir_a, idir_a, idpc_a;
    logic        rst_n_b, redir_b, ready_b, valid_b, halt_b;
    logic [31:0] redir_pc_b, pc_b, ir_b, idir_b, idpc_b;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Instruction memory model: IM[k] = k + 0x100
    assign ir_a = pc_a + 32'h100;
    assign ir_b = pc_b + 32'h100;

    ifetch dut_a (
        .clk           (clk),
        .rst_n         (rst_n_a),
        .pc_o          (pc_a),
        .ir_i          (ir_a),
        .redirect_i    (redir_a),
        .redirect_pc_i (redir_pc_a),
        .id_valid_o    (valid_a),
        .id_ir_o       (idir_a),
        .id_pc_o       (idpc_a),
        .id_ready_i    (ready_a),
        .halt_o        (halt_a)
    );

    ifetch #(.IM_DEPTH(16)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n_b),
        .pc_o          (pc_b),
        .ir_i          (ir_b),
        .redirect_i    (redir_b),
        .redirect_pc_i (redir_pc_b),
        .id_valid_o    (valid_b),
        .id_ir_o       (idir_b),
        .id_pc_o       (idpc_b),
        .id_ready_i    (ready_b),
        .halt_o        (halt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp_a(input logic [31:0] pc, input logic [31:0] ir);
        exp_t e;
        e.pc = pc;
        e.ir = ir;
        exp_a.push_back(e);
    endtask

    task automatic push_exp_b(input logic [31:0] pc, input logic [31:0] ir);
        exp_t e;
        e.pc = pc;
        e.ir = ir;
        exp_b.push_back(e);
    endtask

    always @(negedge clk) begin
        if (valid_a && ready_a) begin
            if (exp_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_extra_pop: got pc %h, required no handshake", idpc_a);
            end else begin
                exp_t e;
                e = exp_a.pop_front();
                check("a_pop_pc", idpc_a, e.pc);
                check("a_pop_ir", idir_a, e.ir);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_extra_pop: got pc %h, required no handshake", idpc_b);
            end else begin
                exp_t e;
                e = exp_b.pop_front();
                check("b_pop_pc", idpc_b, e.pc);
                check("b_pop_ir", idir_b, e.ir);
            end
        end
    end

    initial begin
        rst_n_a = 1'b0; ready_a = 1'b1; redir_a = 1'b0; redir_pc_a = '0;
        rst_n_b = 1'b0; ready_b = 1'b1; redir_b = 1'b0; redir_pc_b = '0;
        cyc();
        cyc();
        check("a_rst_valid", valid_a, 0);
        check("a_rst_id_ir", idir_a, 0);
        check("a_rst_id_pc", idpc_a, 0);
        check("a_rst_pc_o",  pc_a, 0);
        check("a_rst_halt",  halt_a, 0);

        // Stream: cycles 1..5 deliver pc 0..4
        for (int i = 0; i < 5; i++) push_exp_a(i, 32'h100 + i);
        rst_n_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check("a_stream_valid", valid_a, 1);
        end
        cyc();
        ready_a = 1'b0;
        rst_n_a = 1'b0;
        check("a_stream_drained", exp_a.size(), 0);

        // Backpressure: ready low for 4 cycles after first valid
        cyc();
        rst_n_a = 1'b1;
        for (int i = 0; i < 3; i++) push_exp_a(i, 32'h100 + i);
        cyc();
        check("a_bp_first_valid", valid_a, 1);
        check("a_bp_first_pc", idpc_a, 0);
        for (int k = 2; k <= 4; k++) begin
            cyc();
            check("a_bp_pc_o_frozen", pc_a, 2);
            check("a_bp_head_pc", idpc_a, 0);
            check("a_bp_head_ir", idir_a, 32'h100);
        end
        cyc();
        ready_a = 1'b1;
        cyc();
        cyc();
        cyc();
        // Redirect to 40 with two entries buffered
        ready_a = 1'b0;
        redir_a = 1'b1;
        redir_pc_a = 32'd40;
        check("a_bp_drained", exp_a.size(), 0);
        check("a_pre_redir_valid", valid_a, 1);
        push_exp_a(40, 32'h128);
        cyc();
        redir_a = 1'b0;
        check("a_redir_valid", valid_a, 0);
        check("a_redir_pc_o", pc_a, 40);
        cyc();
        check("a_redir_tgt_valid", valid_a, 1);
        check("a_redir_tgt_pc", idpc_a, 40);
        check("a_redir_tgt_ir", idir_a, 32'h128);

        // Redirect with a same-cycle pop: 40 consumed, 41 flushed
        cyc();
        ready_a = 1'b1;
        redir_a = 1'b1;
        redir_pc_a = 32'd20;
        push_exp_a(20, 32'h114);
        cyc();
        redir_a = 1'b0;
        check("a_rp_valid_gap", valid_a, 0);
        check("a_rp_pc_o", pc_a, 20);
        cyc();
        check("a_rp_tgt_valid", valid_a, 1);
        cyc();
        // Reset together with a redirect: reset wins
        ready_a = 1'b0;
        rst_n_a = 1'b0;
        redir_a = 1'b1;
        redir_pc_a = 32'd50;
        check("a_rp_drained", exp_a.size(), 0);
        cyc();
        check("a_mrst_valid", valid_a, 0);
        check("a_mrst_id_ir", idir_a, 0);
        check("a_mrst_id_pc", idpc_a, 0);
        check("a_mrst_pc_o",  pc_a, 0);
        check("a_mrst_halt",  halt_a, 0);
        rst_n_a = 1'b1;
        redir_a = 1'b0;
        ready_a = 1'b1;
        for (int i = 0; i < 3; i++) push_exp_a(i, 32'h100 + i);
        cyc();
        cyc();
        cyc();
        cyc();
        ready_a = 1'b0;
        check("a_mrst_drained", exp_a.size(), 0);

        // End of memory on the 16-word instance
        for (int i = 0; i < 16; i++) push_exp_b(i, 32'h100 + i);
        rst_n_b = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            check("b_stream_valid", valid_b, 1);
        end
        check("b_pc_o_15", pc_b, 15);
        check("b_halt_before_end", halt_b, 0);
        cyc();
        check("b_halt_set", halt_b, 1);
        check("b_pc_o_end", pc_b, 16);
        check("b_last_valid", valid_b, 1);
        for (int k = 17; k <= 19; k++) begin
            cyc();
            check("b_halted_valid", valid_b, 0);
            check("b_halted_pc_o", pc_b, 16);
            check("b_halted_halt", halt_b, 1);
        end
        redir_b = 1'b1;
        redir_pc_b = 32'd3;
        push_exp_b(3, 32'h103);
        cyc();
        redir_b = 1'b0;
        check("b_unhalt", halt_b, 0);
        check("b_unhalt_pc_o", pc_b, 3);
        check("b_unhalt_valid", valid_b, 0);
        cyc();
        check("b_tgt_valid", valid_b, 1);
        cyc();
        ready_b = 1'b0;
        redir_b = 1'b1;
        redir_pc_b = 32'd20;
        check("b_drained", exp_b.size(), 0);
        cyc();
        redir_b = 1'b0;
        check("b_oor_halt", halt_b, 1);
        check("b_oor_valid", valid_b, 0);
        check("b_oor_pc_o", pc_b, 20);
        cyc();
        cyc();
        check("b_oor_hold_valid", valid_b, 0);
        check("b_oor_hold_pc_o", pc_b, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
